ipsxe_fft_frame_chk_mc: RTL and testbench
=========================================

# ipsxe_fft_frame_chk_mc

Multi-channel, run-time-configurable FFT output frame checker for FFT IP example designs and regression benches. It monitors NUM_CH parallel AXI4-Stream result channels behind a common sink-ready, and checks each channel's index order, tlast placement, frame count and stall stability against an FFT length and output order latched at test start. It reports sticky per-channel error flags, a saturating error-event counter and a pass/finished status. Data values are not checked.

## Interface
- NUM_CH, 2: number of monitored result channels, 1..8
- MAX_LOG2_FFT_LEN, 12: largest supported log2 FFT length, 3..16; sets index width
- TEST_FRAME_NUM, 10: frames expected per channel per test, ≥1
- TIMEOUT_WIDTH, 24: timeout counter width; test ends at count 2^TIMEOUT_WIDTH-1
- ERR_CNT_WIDTH, 16: error-event counter width
---
- i_aclk  in  1  clock
- i_areset  in  1  synchronous reset, active-high
- i_aclken  in  1  clock enable; when low, all state holds
- i_cfg_log2_len  in  5  log2 FFT length L, 3..MAX_LOG2_FFT_LEN, sampled on start
- i_cfg_order  in  1  1 natural, 0 bit-reversed, sampled on start
- i_start_test  in  1  single-cycle start pulse
- i_axi4s_data_tvalid  in  NUM_CH  per-channel valid
- i_axi4s_data_tready  in  1  common sink ready, monitored only
- i_axi4s_data_tlast  in  NUM_CH  per-channel last
- i_axi4s_data_tuser  in  NUM_CH*MAX_LOG2_FFT_LEN  per-channel output index; channel c occupies bits [c*MAX_LOG2_FFT_LEN +: MAX_LOG2_FFT_LEN]
- o_chk_finished  out  1  high when idle or done
- o_pass  out  1  finished with no error
- o_err  out  1  OR of all o_err_flags
- o_err_flags  out  NUM_CH*4  sticky per channel c, bits [4c+3:4c] = {stall, frame, tlast, index}
- o_err_cnt  out  ERR_CNT_WIDTH  saturating count of cycles with at least one new error event

## Operation
- FSM states are IDLE, RUN and DONE. Reset enters IDLE.
- IDLE→RUN on start. DONE→RUN on start. A start during RUN restarts the test and does not leave RUN.
- On start:
  - latch L and order
  - clear per-channel data_cnt, frm_cnt and stall history
  - clear o_err_flags, o_err_cnt and o_pass
  - load the timeout counter with 1
- RUN→DONE when every channel has frm_cnt == TEST_FRAME_NUM, or when the timeout counter reaches all-ones. The timeout counter increments every enabled cycle in RUN.
- A beat on channel c is i_aclken & tvalid[c] & tready.
- Index check on each beat: the expected index is data_cnt, or the low L bits of data_cnt reversed when order=0. Compare only the low L bits of tuser; the upper tuser bits must be zero. A mismatch sets the index flag.
- tlast check on each beat: tlast[c] must equal (data_cnt == 2^L-1). A mismatch sets the tlast flag.
- data_cnt advances on every beat and wraps from 2^L-1 to 0 whatever tlast is.
- frm_cnt increments on a beat with tlast and saturates at TEST_FRAME_NUM.
- A beat arriving while frm_cnt == TEST_FRAME_NUM sets the frame flag.
- On entry to DONE, any channel with frm_cnt ≠ TEST_FRAME_NUM gets its frame flag set.
- Stall check: if an enabled cycle has tvalid[c] & ~tready, the next enabled cycle must keep tvalid[c]=1 with tuser and tlast unchanged. Otherwise the stall flag is set.
- Beats and errors in IDLE or DONE are ignored.
- o_err_cnt increments by 1 in any cycle where at least one flag event occurs, even if that flag is already set. It holds at all-ones.
- o_pass is set on entry to DONE if no flag is set, including the frame flags set on that same entry.

## Timing
- Reset values: state IDLE, o_chk_finished=1, o_pass=0, o_err=0, o_err_flags=0, o_err_cnt=0; all counters 0.
- Flags and o_err_cnt update on the clock edge after the offending beat or cycle, so they are visible 1 cycle later. o_err is combinational from the flags.
- o_chk_finished goes to 0 on the edge after start and returns to 1 on the edge that enters DONE. o_pass is valid in the same cycle.
- The end-of-test frame check and o_pass use the same edge.
- Beats in the start cycle are ignored. Checking starts the cycle after start.
- Reset asserted mid-RUN returns everything to reset values on the next edge.
- While i_aclken is low, the FSM, counters and stall history hold.

## Test plan
- Natural order: NUM_CH=2, L=4, order=1, 10 clean 16-beat frames per channel with tready=1. Expect o_chk_finished rising, o_pass=1, o_err_flags=0, o_err_cnt=0.
- Bit-reversed order with L=3: tuser sequence 0,4,2,6,1,5,3,7. Expect no flags. Then swap beats 1 and 2 on channel 1. Expect flag bit 4 set one cycle later and o_err_cnt=2.
- tlast misplaced: with L=4, assert tlast on beat 14 of channel 0. Expect the tlast flag (bit 1) set. Running to timeout, also expect the frame flag (bit 2) set at DONE and o_pass=0.
- Backpressure: hold tready=0 for 3 cycles with tvalid held stable; expect no error. Then drop tvalid[0] during the stall. Expect the stall flag (bit 3) and o_err_cnt=1.
- Timeout: TIMEOUT_WIDTH=8, send only 9 frames. Expect DONE 255 cycles after start, frame flags set, o_pass=0.
- Restart and clock enable: issue start mid-RUN with an error already flagged. Expect flags and counter cleared and the test rerunning to a pass. Toggle i_aclken every other cycle and expect an identical result.

Source files
------------

// File: rtl/ipsxe_fft_frame_chk_mc_if.sv
// Result-stream bundle for the FFT frame checker: per-channel valid/last/index
// plus one shared sink ready.
interface ipsxe_fft_frame_chk_mc_if #(
  parameter int NUM_CH           = 2,
  parameter int MAX_LOG2_FFT_LEN = 12
);
  logic [NUM_CH-1:0]                  tvalid;
  logic                               tready;
  logic [NUM_CH-1:0]                  tlast;
  logic [NUM_CH*MAX_LOG2_FFT_LEN-1:0] tuser;

  modport master (output tvalid, output tready, output tlast, output tuser);
  modport slave  (input  tvalid, input  tready, input  tlast, input  tuser);
endinterface

// File: rtl/ipsxe_fft_frame_chk_mc.sv
// Multi-channel FFT output frame checker: verifies index order, tlast placement,
// frame count and stall stability per channel against a length/order latched at start.
module ipsxe_fft_frame_chk_mc #(
  parameter int NUM_CH           = 2,
  parameter int MAX_LOG2_FFT_LEN = 12,
  parameter int TEST_FRAME_NUM   = 10,
  parameter int TIMEOUT_WIDTH    = 24,
  parameter int ERR_CNT_WIDTH    = 16
) (
  input  logic                        i_aclk,
  input  logic                        i_areset,
  input  logic                        i_aclken,
  input  logic [4:0]                  i_cfg_log2_len,
  input  logic                        i_cfg_order,
  input  logic                        i_start_test,
  ipsxe_fft_frame_chk_mc_if.slave     axi4s_data,
  output logic                        o_chk_finished,
  output logic                        o_pass,
  output logic                        o_err,
  output logic [NUM_CH*4-1:0]         o_err_flags,
  output logic [ERR_CNT_WIDTH-1:0]    o_err_cnt
);

  localparam int W  = MAX_LOG2_FFT_LEN;
  localparam int FW = $clog2(TEST_FRAME_NUM + 1);
  localparam logic [FW-1:0] FRM_FULL = FW'(TEST_FRAME_NUM);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]               state;
  logic [4:0]               len_q;
  logic                     order_q;
  logic [TIMEOUT_WIDTH-1:0] to_cnt;
  logic [NUM_CH*4-1:0]      err_flags;
  logic [ERR_CNT_WIDTH-1:0] err_cnt;
  logic                     pass_q;
  logic [W-1:0]             data_cnt   [NUM_CH];
  logic [FW-1:0]            frm_cnt    [NUM_CH];
  logic [NUM_CH-1:0]        stall_pend;
  logic [W-1:0]             stall_user [NUM_CH];
  logic [NUM_CH-1:0]        stall_last;

  logic [W-1:0]             mask;
  logic [W-1:0]             user       [NUM_CH];
  logic [FW-1:0]            frm_nxt    [NUM_CH];
  logic [NUM_CH-1:0]        beat;
  logic [NUM_CH*4-1:0]      new_flags;
  logic [NUM_CH*4-1:0]      flags_nxt;
  logic                     chk;
  logic                     all_full;
  logic                     enter_done;
  logic                     any_ev;

  function automatic logic [W-1:0] bit_rev(input logic [W-1:0] v, input logic [4:0] len);
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W; i++) begin
      if (i < int'(len)) r[i] = v[int'(len) - 1 - i];
    end
    return r;
  endfunction

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_inc(input logic [ERR_CNT_WIDTH-1:0] v);
    return (&v) ? v : v + ERR_CNT_WIDTH'(1);
  endfunction

  assign mask = W'((32'd1 << len_q) - 32'd1);

  // Per-channel event detection for the current cycle
  always_comb begin
    chk        = (state == ST_RUN) && !i_start_test;
    all_full   = 1'b1;
    for (int c = 0; c < NUM_CH; c++) all_full = all_full & (frm_cnt[c] == FRM_FULL);
    enter_done = chk && (all_full || (&to_cnt));
    beat       = '0;
    new_flags  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      logic [W-1:0] exp_idx;
      logic         ev_idx, ev_last, ev_frm, ev_stall;
      user[c]    = axi4s_data.tuser[c*W +: W];
      beat[c]    = chk && axi4s_data.tvalid[c] && axi4s_data.tready;
      exp_idx    = order_q ? data_cnt[c] : bit_rev(data_cnt[c], len_q);
      ev_idx     = beat[c] && (((user[c] & mask) != exp_idx) || ((user[c] & ~mask) != '0));
      ev_last    = beat[c] && (axi4s_data.tlast[c] != (data_cnt[c] == mask));
      frm_nxt[c] = (beat[c] && axi4s_data.tlast[c] && (frm_cnt[c] != FRM_FULL))
                   ? frm_cnt[c] + FW'(1) : frm_cnt[c];
      // A short channel at test end counts as a frame error on that same edge
      ev_frm     = (beat[c] && (frm_cnt[c] == FRM_FULL)) ||
                   (enter_done && (frm_nxt[c] != FRM_FULL));
      ev_stall   = chk && stall_pend[c] &&
                   (!axi4s_data.tvalid[c] || (user[c] != stall_user[c]) ||
                    (axi4s_data.tlast[c] != stall_last[c]));
      new_flags[4*c +: 4] = {ev_stall, ev_frm, ev_last, ev_idx};
    end
    flags_nxt = err_flags | new_flags;
    any_ev    = |new_flags;
  end

  // Control and counter state
  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      state      <= ST_IDLE;
      len_q      <= '0;
      order_q    <= 1'b0;
      to_cnt     <= '0;
      err_flags  <= '0;
      err_cnt    <= '0;
      pass_q     <= 1'b0;
      stall_pend <= '0;
      stall_last <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        data_cnt[c]   <= '0;
        frm_cnt[c]    <= '0;
        stall_user[c] <= '0;
      end
    end else if (i_aclken) begin
      if (i_start_test) begin
        state      <= ST_RUN;
        len_q      <= i_cfg_log2_len;
        order_q    <= i_cfg_order;
        to_cnt     <= TIMEOUT_WIDTH'(1);
        err_flags  <= '0;
        err_cnt    <= '0;
        pass_q     <= 1'b0;
        stall_pend <= '0;
        for (int c = 0; c < NUM_CH; c++) begin
          data_cnt[c] <= '0;
          frm_cnt[c]  <= '0;
        end
      end else if (state == ST_RUN) begin
        to_cnt    <= to_cnt + TIMEOUT_WIDTH'(1);
        err_flags <= flags_nxt;
        if (any_ev) err_cnt <= sat_inc(err_cnt);
        for (int c = 0; c < NUM_CH; c++) begin
          if (beat[c]) data_cnt[c] <= (data_cnt[c] == mask) ? '0 : data_cnt[c] + W'(1);
          frm_cnt[c]    <= frm_nxt[c];
          stall_pend[c] <= axi4s_data.tvalid[c] & ~axi4s_data.tready;
          stall_user[c] <= user[c];
          stall_last[c] <= axi4s_data.tlast[c];
        end
        if (enter_done) begin
          state  <= ST_DONE;
          pass_q <= (flags_nxt == '0);
        end
      end
    end
  end

  assign o_chk_finished = (state != ST_RUN);
  assign o_pass         = pass_q;
  assign o_err          = |err_flags;
  assign o_err_flags    = err_flags;
  assign o_err_cnt      = err_cnt;

endmodule

// File: tb/tb_ipsxe_fft_frame_chk_mc.sv
// Directed bench for ipsxe_fft_frame_chk_mc: a cycle-by-cycle vector table for the
// bit-reversed/backpressure cases plus hand sequences for whole-test scenarios.
module tb_ipsxe_fft_frame_chk_mc;

  localparam int NCH = 2;
  localparam int MW  = 12;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [4:0]  cfg_len;
  logic        cfg_order;
  logic        start;
  logic        fin, pass, err;
  logic [7:0]  flags;
  logic [15:0] ecnt;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;

  ipsxe_fft_frame_chk_mc_if #(.NUM_CH(NCH), .MAX_LOG2_FFT_LEN(MW)) bus ();

  ipsxe_fft_frame_chk_mc #(
    .NUM_CH(NCH), .MAX_LOG2_FFT_LEN(MW), .TEST_FRAME_NUM(10),
    .TIMEOUT_WIDTH(8), .ERR_CNT_WIDTH(16)
  ) dut (
    .i_aclk(clk), .i_areset(rst), .i_aclken(en),
    .i_cfg_log2_len(cfg_len), .i_cfg_order(cfg_order), .i_start_test(start),
    .axi4s_data(bus),
    .o_chk_finished(fin), .o_pass(pass), .o_err(err),
    .o_err_flags(flags), .o_err_cnt(ecnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        s;
    logic [1:0]  v;
    logic        r;
    logic [1:0]  l;
    logic [11:0] u0;
    logic [11:0] u1;
    logic [7:0]  flags;
    logic [15:0] cnt;
    logic        fin;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic step(input logic s, input logic [1:0] v, input logic r, input logic [1:0] l,
                      input logic [11:0] u0, input logic [11:0] u1, input logic e);
    start      = s;
    bus.tvalid = v;
    bus.tready = r;
    bus.tlast  = l;
    bus.tuser  = {u1, u0};
    en         = e;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // One accepted beat; in toggle mode it is preceded by a disabled cycle carrying junk
  task automatic beat(input logic [1:0] v, input logic r, input logic [1:0] l,
                      input logic [11:0] u0, input logic [11:0] u1, input bit tog);
    if (tog) step(1'b0, 2'b11, 1'b1, 2'b11, 12'($urandom), 12'($urandom), 1'b0);
    step(1'b0, v, r, l, u0, u1, 1'b1);
  endtask

  function automatic logic [11:0] rev(input int v, input int len);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < len; i++) if (v & (1 << i)) r[len-1-i] = 1'b1;
    return r;
  endfunction

  task automatic send_frames(input int len, input bit order, input int nfr, input bit tog);
    for (int f = 0; f < nfr; f++) begin
      for (int i = 0; i < (1 << len); i++) begin
        logic [11:0] idx;
        idx = order ? 12'(i) : rev(i, len);
        beat(2'b11, 1'b1, (i == (1 << len) - 1) ? 2'b11 : 2'b00, idx, idx, tog);
      end
    end
  endtask

  task automatic wait_fin(input int max, output int n);
    n = 0;
    while (fin !== 1'b1 && n < max) begin
      step(1'b0, 2'b00, 1'b1, 2'b00, 12'd0, 12'd0, 1'b1);
      n++;
    end
    check("wait_fin_bound", 32'(fin), 32'd1);
  endtask

  task automatic add(input int s, input int v, input int r, input int l, input int u0,
                     input int u1, input int f, input int c, input int fn);
    vec_t t;
    t.s = 1'(s); t.v = 2'(v); t.r = 1'(r); t.l = 2'(l);
    t.u0 = 12'(u0); t.u1 = 12'(u1); t.flags = 8'(f); t.cnt = 16'(c); t.fin = 1'(fn);
    vq.push_back(t);
  endtask

  initial begin
    int seq[8];
    int sw[8];
    int n;
    int t0;
    seq = '{0, 4, 2, 6, 1, 5, 3, 7};
    sw  = '{0, 2, 1, 3, 4, 5, 6, 7};

    rst = 1'b1; en = 1'b1; cfg_len = 5'd4; cfg_order = 1'b1; start = 1'b0;
    bus.tvalid = '0; bus.tready = 1'b1; bus.tlast = '0; bus.tuser = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    step(1'b0, 2'b00, 1'b1, 2'b00, 12'd0, 12'd0, 1'b1);
    check("rst_fin",   32'(fin),   32'd1);
    check("rst_pass",  32'(pass),  32'd0);
    check("rst_err",   32'(err),   32'd0);
    check("rst_flags", 32'(flags), 32'd0);
    check("rst_cnt",   32'(ecnt),  32'd0);

    // Natural order, L=4, 10 clean frames
    cfg_len = 5'd4; cfg_order = 1'b1;
    step(1'b1, 2'b11, 1'b1, 2'b11, 12'd9, 12'd9, 1'b1);
    check("nat_fin_low", 32'(fin), 32'd0);
    send_frames(4, 1'b1, 10, 1'b0);
    check("nat_fin_before_done", 32'(fin), 32'd0);
    wait_fin(5, n);
    check("nat_done_latency", 32'(n), 32'd1);
    check("nat_pass",  32'(pass),  32'd1);
    check("nat_flags", 32'(flags), 32'd0);
    check("nat_cnt",   32'(ecnt),  32'd0);

    // Vector table: bit-reversed L=3 clean/swapped frames, then backpressure
    cfg_len = 5'd3; cfg_order = 1'b0;
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 3, 1, (i == 7) ? 3 : 0, seq[i], seq[i], 0, 0, 0);
    for (int i = 0; i < 8; i++)
      add(0, 3, 1, (i == 7) ? 3 : 0, seq[i], seq[sw[i]], (i >= 1) ? 8'h10 : 0,
          (i == 0) ? 0 : ((i == 1) ? 1 : 2), 0);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(0, 3, 0, 0, 0, 0, 0, 0, 0);
    add(0, 3, 1, 0, 0, 0, 0, 0, 0);
    add(0, 3, 0, 0, 4, 4, 0, 0, 0);
    add(0, 2, 0, 0, 0, 4, 8'h08, 1, 0);
    add(0, 3, 1, 0, 4, 4, 8'h08, 1, 0);
    foreach (vq[k]) begin
      step(vq[k].s, vq[k].v, vq[k].r, vq[k].l, vq[k].u0, vq[k].u1, 1'b1);
      check($sformatf("vec%0d_flags", k), 32'(flags), 32'(vq[k].flags));
      check($sformatf("vec%0d_cnt", k),   32'(ecnt),  32'(vq[k].cnt));
      check($sformatf("vec%0d_fin", k),   32'(fin),   32'(vq[k].fin));
    end

    // tlast early on beat 14 of channel 0, then run short to timeout
    cfg_len = 5'd4; cfg_order = 1'b1;
    step(1'b1, 2'b00, 1'b1, 2'b00, 12'd0, 12'd0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      beat(2'b11, 1'b1, {1'(i == 15), 1'(i == 14 || i == 15)}, 12'(i), 12'(i), 1'b0);
      if (i == 14) begin
        check("tlast_flag", 32'(flags), 32'h02);
        check("tlast_cnt",  32'(ecnt),  32'd1);
      end
    end
    send_frames(4, 1'b1, 4, 1'b0);
    wait_fin(300, n);
    check("tlast_end_flags", 32'(flags), 32'h46);
    check("tlast_end_pass",  32'(pass),  32'd0);
    check("tlast_end_err",   32'(err),   32'd1);
    check("tlast_end_cnt",   32'(ecnt),  32'd2);

    // Timeout with only 9 frames
    cfg_len = 5'd3; cfg_order = 1'b1;
    step(1'b1, 2'b00, 1'b1, 2'b00, 12'd0, 12'd0, 1'b1);
    t0 = cyc;
    send_frames(3, 1'b1, 9, 1'b0);
    wait_fin(300, n);
    check("to_latency", 32'(cyc - t0), 32'd255);
    check("to_flags",   32'(flags),    32'h44);
    check("to_pass",    32'(pass),     32'd0);
    check("to_cnt",     32'(ecnt),     32'd1);

    // Restart mid-run with an error flagged, with and without clock-enable gaps
    for (int tog = 0; tog < 2; tog++) begin
      cfg_len = 5'd4; cfg_order = 1'b1;
      step(1'b1, 2'b00, 1'b1, 2'b00, 12'd0, 12'd0, 1'b1);
      for (int i = 0; i < 6; i++) begin
        beat(2'b11, 1'b1, 2'b00, 12'(i), (i == 3) ? 12'd9 : 12'(i), 1'(tog));
        if (i == 3) begin
          check($sformatf("rs%0d_err_flag", tog), 32'(flags), 32'h10);
          check($sformatf("rs%0d_err_cnt", tog),  32'(ecnt),  32'd1);
        end
      end
      step(1'b1, 2'b11, 1'b1, 2'b11, 12'd7, 12'd7, 1'b1);
      check($sformatf("rs%0d_clr_flags", tog), 32'(flags), 32'd0);
      check($sformatf("rs%0d_clr_cnt", tog),   32'(ecnt),  32'd0);
      check($sformatf("rs%0d_clr_fin", tog),   32'(fin),   32'd0);
      send_frames(4, 1'b1, 10, 1'(tog));
      wait_fin(10, n);
      check($sformatf("rs%0d_latency", tog), 32'(n),     32'd1);
      check($sformatf("rs%0d_pass", tog),    32'(pass),  32'd1);
      check($sformatf("rs%0d_flags", tog),   32'(flags), 32'd0);
      check($sformatf("rs%0d_cnt", tog),     32'(ecnt),  32'd0);
    end

    // Reset in the middle of a run with an error pending
    step(1'b1, 2'b00, 1'b1, 2'b00, 12'd0, 12'd0, 1'b1);
    beat(2'b11, 1'b1, 2'b00, 12'd5, 12'd0, 1'b0);
    check("mr_flag", 32'(flags), 32'h01);
    rst = 1'b1;
    step(1'b0, 2'b11, 1'b1, 2'b00, 12'd1, 12'd1, 1'b1);
    rst = 1'b0;
    check("mr_fin",   32'(fin),   32'd1);
    check("mr_flags", 32'(flags), 32'd0);
    check("mr_cnt",   32'(ecnt),  32'd0);
    check("mr_pass",  32'(pass),  32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
